lvds_frame_rx: RTL and testbench
================================

# lvds_frame_rx

Readout-side receiver that consumes the 24-bit `LVDS` word stream produced by `mod_top` and recovers per-frame hit records (12-bit pixel address for the 4096-pixel matrix plus 8-bit timestamp). It parses header, data and trailer words, checks frame sequence and hit count, and buffers recovered hits in a small FIFO with a valid/ready output. It also keeps frame and error statistics. It sits directly downstream of `mod_top`, on the `clk3` readout clock.

## Interface
- `FIFO_DEPTH`, 8, hit FIFO entries (power of 2, ≥2)
- `ERR_W`, 8, width of saturating error counter
- `clk3`  in  1  readout clock; all logic on rising edge
- `sys_reset`  in  1  asynchronous, active-low reset
- `LVDS`  in  24  word from `mod_top`, one per `clk3` cycle
- `hit_addr`  out  12  FIFO head: pixel address
- `hit_ts`  out  8  FIFO head: timestamp
- `hit_valid`  out  1  FIFO non-empty
- `hit_ready`  in  1  consumer pops head when `hit_valid & hit_ready`
- `frame_done`  out  1  one-cycle pulse per accepted trailer
- `frame_ok`  out  1  result of last closed frame (1 = no error in that frame)
- `frame_num`  out  16  frame number of last header accepted
- `frame_cnt`  out  16  trailers accepted since reset, wraps
- `err_flags`  out  4  sticky: [0] seq, [1] count, [2] orphan/framing, [3] overflow
- `err_cnt`  out  ERR_W  total error events, saturates at all-ones

## Operation
- Word type is `LVDS[23:22]`: `00` idle (ignored); `10` header, with frame number in `[15:0]`; `01` data, with timestamp in `[19:12]` and address in `[11:0]`; `11` trailer, with hit count in `[15:0]`.
- Input register `lvds_q` captures `LVDS` every cycle. The parser acts on `lvds_q`.
- FSM states:
  - `IDLE`:
    - header → `IN_FRAME`; load `frame_num`; clear the per-frame hit counter `fhits` (16 bit) and the frame error flag.
    - data or trailer → orphan error; word dropped.
  - `IN_FRAME`:
    - data → push to FIFO; `fhits+1`.
    - trailer → `IDLE`; pulse `frame_done`; `frame_cnt+1`; `frame_ok = ~(frame error)`; if `fhits != count` → count error.
    - header → framing error. Close the current frame as for a trailer with `frame_ok=0` and no count check. Open the new frame in the same cycle.
- Sequence check: a header with number ≠ previous header number + 1 (mod 2^16) is a seq error and marks the new frame bad. The first header after reset is exempt. Wrap `FFFF→0000` is legal.
- FIFO: push when full drops the word, raises overflow error, marks the frame bad, and does not increment `fhits`. Push and pop in the same cycle on a full FIFO are both accepted (no drop).
- Each error event sets its `err_flags` bit (sticky until reset) and adds 1 to `err_cnt`, saturating. At most one increment per cycle.
- Reset: state `IDLE`, FIFO empty, `lvds_q`=0. All outputs are 0, including `hit_*`, `frame_*`, `err_*`; `frame_ok`=0. Reset mid-frame discards the frame with no pulse and no count.

## Timing
- Word on `LVDS` at edge N is captured into `lvds_q` at edge N and parsed at edge N+1. `hit_valid` is high after edge N+1 (show-ahead FIFO, 2-cycle latency). `frame_done` is high for the cycle following edge N+1. Statistics update at edge N+1.
- Throughput: one word per cycle, sustained. Back-to-back frames need no idle words between them.
- `hit_addr`/`hit_ts` are stable while `hit_valid & ~hit_ready`. A pop takes effect at the edge where `hit_valid & hit_ready`.
- `err_flags`, `err_cnt`, `frame_ok`, `frame_num` are registered outputs.

## Test plan
- Header 0x0000, data (ts 0x11, addr 0x005), (0x12, 0xFFF), (0x13, 0x800), trailer count 3, `hit_ready`=1 → three hits out in order, `hit_valid` 2 cycles after first data; one `frame_done`; `frame_ok`=1; `frame_cnt`=1; `err_cnt`=0.
- Frames numbered 0x0005 then 0x0007 → `err_flags[0]`=1; `err_cnt`=1; second `frame_ok`=0. Frames 0xFFFF then 0x0000 → no error.
- Trailer count 4 after 3 data words → `err_flags[1]`=1; `frame_ok`=0. Data word while `IDLE` → `err_flags[2]`=1; no hit output.
- `hit_ready`=0, one frame with 10 data, trailer count 10 → 8 hits buffered; `err_flags[3]`=1. The count check is also flagged (`fhits`=8), so `err_cnt`=3 (2 overflow + 1 count). Release `hit_ready` → exactly 8 hits drained.
- Header, 2 data, second header (no trailer), 1 data, trailer 1 → first frame `frame_ok`=0 with `err_flags[2]`; second frame `frame_ok`=1; `frame_cnt`=2.
- Assert `sys_reset` low mid-frame with 3 hits buffered → all outputs 0 immediately (asynchronous). After release, a new header is exempt from the seq check.

Source files
------------

// File: rtl/lvds_frame_rx.sv
// rtl/lvds_frame_rx.sv - LVDS frame parser with hit FIFO and frame/error statistics
module lvds_frame_rx #(
    parameter int FIFO_DEPTH = 8,
    parameter int ERR_W      = 8
) (
    input  logic             clk3,
    input  logic             sys_reset,
    input  logic [23:0]      LVDS,
    output logic [11:0]      hit_addr,
    output logic [7:0]       hit_ts,
    output logic             hit_valid,
    input  logic             hit_ready,
    output logic             frame_done,
    output logic             frame_ok,
    output logic [15:0]      frame_num,
    output logic [15:0]      frame_cnt,
    output logic [3:0]       err_flags,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic {IDLE, IN_FRAME} state_t;

    state_t          state;
    logic [23:0]     lvds_q;
    logic [15:0]     fhits;
    logic            frame_bad;
    logic            seen_hdr;
    logic [19:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;

    logic            is_hdr, is_data, is_trl;
    logic [15:0]     next_num;
    logic            seq_err, cnt_err, orphan_err, ovf_err, any_err;
    logic            full, pop, push_req, push;
    logic            unused_bits;

    // Word decode and per-cycle error event detection on the registered word
    always_comb begin
        is_hdr     = (lvds_q[23:22] == 2'b10);
        is_data    = (lvds_q[23:22] == 2'b01);
        is_trl     = (lvds_q[23:22] == 2'b11);
        next_num   = frame_num + 16'd1;
        full       = (count == FULL_CNT);
        pop        = hit_valid & hit_ready;
        push_req   = (state == IN_FRAME) && is_data;
        // A full FIFO still accepts a push when the head leaves in the same cycle
        push       = push_req && (!full || pop);
        ovf_err    = push_req && !push;
        // The very first header after reset has no predecessor to compare against
        seq_err    = is_hdr && seen_hdr && (lvds_q[15:0] != next_num);
        cnt_err    = (state == IN_FRAME) && is_trl && (fhits != lvds_q[15:0]);
        orphan_err = ((state == IDLE) && (is_data || is_trl)) ||
                     ((state == IN_FRAME) && is_hdr);
        any_err    = seq_err | cnt_err | orphan_err | ovf_err;
    end

    assign unused_bits = ^lvds_q[21:20];

    // Show-ahead head; forced to zero when nothing is buffered
    assign hit_valid = (count != '0);
    assign hit_addr  = hit_valid ? mem[rd_ptr][11:0]  : 12'd0;
    assign hit_ts    = hit_valid ? mem[rd_ptr][19:12] : 8'd0;

    // Input register: every word is parsed one cycle after capture
    always_ff @(posedge clk3 or negedge sys_reset) begin
        if (!sys_reset) lvds_q <= 24'd0;
        else            lvds_q <= LVDS;
    end

    // FIFO storage; contents need no reset because the head is gated by hit_valid
    always_ff @(posedge clk3) begin
        if (push) mem[wr_ptr] <= lvds_q[19:0];
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk3 or negedge sys_reset) begin
        if (!sys_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Frame parser FSM with registered frame status outputs
    always_ff @(posedge clk3 or negedge sys_reset) begin
        if (!sys_reset) begin
            state      <= IDLE;
            fhits      <= 16'd0;
            frame_bad  <= 1'b0;
            seen_hdr   <= 1'b0;
            frame_num  <= 16'd0;
            frame_cnt  <= 16'd0;
            frame_done <= 1'b0;
            frame_ok   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (is_hdr) begin
                        state     <= IN_FRAME;
                        frame_num <= lvds_q[15:0];
                        seen_hdr  <= 1'b1;
                        fhits     <= 16'd0;
                        frame_bad <= seq_err;
                    end
                end
                IN_FRAME: begin
                    if (is_data) begin
                        if (push) fhits     <= fhits + 16'd1;
                        else      frame_bad <= 1'b1;
                    end else if (is_trl) begin
                        state      <= IDLE;
                        frame_done <= 1'b1;
                        frame_cnt  <= frame_cnt + 16'd1;
                        frame_ok   <= ~(frame_bad | cnt_err);
                    end else if (is_hdr) begin
                        // Missing trailer: close the old frame as bad and open the new one
                        frame_done <= 1'b1;
                        frame_cnt  <= frame_cnt + 16'd1;
                        frame_ok   <= 1'b0;
                        frame_num  <= lvds_q[15:0];
                        fhits      <= 16'd0;
                        frame_bad  <= seq_err;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sticky error flags and saturating event counter (one count per cycle at most)
    always_ff @(posedge clk3 or negedge sys_reset) begin
        if (!sys_reset) begin
            err_flags <= 4'd0;
            err_cnt   <= '0;
        end else begin
            err_flags <= err_flags | {ovf_err, orphan_err, cnt_err, seq_err};
            if (any_err && (err_cnt != {ERR_W{1'b1}})) err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_lvds_frame_rx.sv
// tb/tb_lvds_frame_rx.sv - directed self-checking bench for lvds_frame_rx
module tb_lvds_frame_rx;

    logic        clk3 = 1'b0;
    logic        sys_reset = 1'b0;
    logic [23:0] LVDS = 24'd0;
    logic [11:0] hit_addr;
    logic [7:0]  hit_ts;
    logic        hit_valid;
    logic        hit_ready = 1'b0;
    logic        frame_done;
    logic        frame_ok;
    logic [15:0] frame_num;
    logic [15:0] frame_cnt;
    logic [3:0]  err_flags;
    logic [7:0]  err_cnt;

    int n_cmp = 0;
    int n_fail = 0;
    int fd_n = 0;
    logic [19:0] hit_q[$];

    lvds_frame_rx #(.FIFO_DEPTH(8), .ERR_W(8)) dut (
        .clk3(clk3), .sys_reset(sys_reset), .LVDS(LVDS),
        .hit_addr(hit_addr), .hit_ts(hit_ts), .hit_valid(hit_valid), .hit_ready(hit_ready),
        .frame_done(frame_done), .frame_ok(frame_ok), .frame_num(frame_num),
        .frame_cnt(frame_cnt), .err_flags(err_flags), .err_cnt(err_cnt)
    );

    always #5 clk3 = ~clk3;

    // Record popped hits and frame_done pulses mid-cycle
    always @(negedge clk3) begin
        if (sys_reset) begin
            if (hit_valid && hit_ready) hit_q.push_back({hit_ts, hit_addr});
            if (frame_done) fd_n++;
        end
    end

    function automatic logic [23:0] hdr(input logic [15:0] n);
        return {2'b10, 6'd0, n};
    endfunction
    function automatic logic [23:0] dat(input logic [7:0] ts, input logic [11:0] a);
        return {2'b01, 2'b00, ts, a};
    endfunction
    function automatic logic [23:0] trl(input logic [15:0] c);
        return {2'b11, 6'd0, c};
    endfunction

    task automatic put(input logic [23:0] w);
        LVDS = w;
        @(posedge clk3);
        #1;
    endtask

    task automatic do_reset();
        sys_reset = 1'b0;
        LVDS = 24'd0;
        repeat (2) @(posedge clk3);
        #1;
        sys_reset = 1'b1;
        hit_q.delete();
        fd_n = 0;
    endtask

    task automatic test_reset();
        logic [75:0] all;
        do_reset();
        all = {hit_addr, hit_ts, hit_valid, frame_done, frame_ok, frame_num, frame_cnt, err_flags, err_cnt};
        n_cmp++;
        if (all !== 76'd0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", all); end
    endtask

    task automatic test_basic();
        logic [19:0] exp [3];
        exp[0] = {8'h11, 12'h005}; exp[1] = {8'h12, 12'hFFF}; exp[2] = {8'h13, 12'h800};
        do_reset();
        hit_ready = 1'b1;
        put(hdr(16'h0000));
        put(dat(8'h11, 12'h005));
        n_cmp++;
        if (hit_valid !== 1'b0) begin n_fail++; $display("FAIL basic_latency_early: got %b want 0", hit_valid); end
        put(dat(8'h12, 12'hFFF));
        n_cmp++;
        if ({hit_valid, hit_ts, hit_addr} !== {1'b1, 8'h11, 12'h005}) begin
            n_fail++; $display("FAIL basic_first_head: got %h want %h", {hit_valid, hit_ts, hit_addr}, {1'b1, 8'h11, 12'h005});
        end
        put(dat(8'h13, 12'h800));
        put(trl(16'd3));
        put(24'd0);
        n_cmp++;
        if (frame_done !== 1'b1) begin n_fail++; $display("FAIL basic_done_pulse: got %b want 1", frame_done); end
        put(24'd0);
        n_cmp++;
        if (frame_done !== 1'b0) begin n_fail++; $display("FAIL basic_done_width: got %b want 0", frame_done); end
        repeat (3) put(24'd0);
        n_cmp++;
        if (hit_q.size() != 3) begin n_fail++; $display("FAIL basic_hit_count: got %0d want 3", hit_q.size()); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (i < hit_q.size() && hit_q[i] !== exp[i]) begin
                n_fail++; $display("FAIL basic_hit%0d: got %h want %h", i, hit_q[i], exp[i]);
            end
        end
        n_cmp++;
        if ({fd_n[7:0], frame_ok, frame_cnt, err_flags, err_cnt} !== {8'd1, 1'b1, 16'd1, 4'd0, 8'd0}) begin
            n_fail++; $display("FAIL basic_stats: got %h want %h", {fd_n[7:0], frame_ok, frame_cnt, err_flags, err_cnt},
                                {8'd1, 1'b1, 16'd1, 4'd0, 8'd0});
        end
    endtask

    task automatic test_seq();
        do_reset();
        hit_ready = 1'b1;
        put(hdr(16'h0005)); put(trl(16'd0));
        put(hdr(16'h0007)); put(trl(16'd0));
        put(24'd0); put(24'd0);
        n_cmp++;
        if ({err_flags, err_cnt, frame_ok, frame_cnt} !== {4'b0001, 8'd1, 1'b0, 16'd2}) begin
            n_fail++; $display("FAIL seq_gap: got %h want %h", {err_flags, err_cnt, frame_ok, frame_cnt}, {4'b0001, 8'd1, 1'b0, 16'd2});
        end
        do_reset();
        put(hdr(16'hFFFF)); put(trl(16'd0));
        put(hdr(16'h0000)); put(trl(16'd0));
        put(24'd0); put(24'd0);
        n_cmp++;
        if ({err_flags, err_cnt, frame_ok, frame_num} !== {4'b0000, 8'd0, 1'b1, 16'h0000}) begin
            n_fail++; $display("FAIL seq_wrap: got %h want %h", {err_flags, err_cnt, frame_ok, frame_num}, {4'b0000, 8'd0, 1'b1, 16'h0000});
        end
    endtask

    task automatic test_count_orphan();
        do_reset();
        hit_ready = 1'b1;
        put(hdr(16'h0001));
        put(dat(8'h01, 12'h001)); put(dat(8'h02, 12'h002)); put(dat(8'h03, 12'h003));
        put(trl(16'd4));
        put(24'd0); put(24'd0);
        n_cmp++;
        if ({err_flags, err_cnt, frame_ok} !== {4'b0010, 8'd1, 1'b0}) begin
            n_fail++; $display("FAIL count_err: got %h want %h", {err_flags, err_cnt, frame_ok}, {4'b0010, 8'd1, 1'b0});
        end
        put(dat(8'h44, 12'h444));
        repeat (4) put(24'd0);
        n_cmp++;
        if ({err_flags, err_cnt} !== {4'b0110, 8'd2}) begin
            n_fail++; $display("FAIL orphan_err: got %h want %h", {err_flags, err_cnt}, {4'b0110, 8'd2});
        end
        n_cmp++;
        if (hit_q.size() != 3) begin n_fail++; $display("FAIL orphan_no_hit: got %0d want 3", hit_q.size()); end
    endtask

    task automatic test_overflow();
        do_reset();
        hit_ready = 1'b0;
        put(hdr(16'h0000));
        for (int i = 0; i < 10; i++) put(dat(8'h20 + 8'(i), 12'h100 + 12'(i)));
        put(trl(16'd10));
        put(24'd0); put(24'd0);
        n_cmp++;
        if ({err_flags, err_cnt, frame_ok, hit_valid} !== {4'b1010, 8'd3, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL ovf_stats: got %h want %h", {err_flags, err_cnt, frame_ok, hit_valid}, {4'b1010, 8'd3, 1'b0, 1'b1});
        end
        n_cmp++;
        if ({hit_ts, hit_addr} !== {8'h20, 12'h100}) begin
            n_fail++; $display("FAIL ovf_head_hold: got %h want %h", {hit_ts, hit_addr}, {8'h20, 12'h100});
        end
        hit_ready = 1'b1;
        repeat (12) put(24'd0);
        n_cmp++;
        if (hit_q.size() != 8) begin n_fail++; $display("FAIL ovf_drain_count: got %0d want 8", hit_q.size()); end
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (i < hit_q.size() && hit_q[i] !== {8'h20 + 8'(i), 12'h100 + 12'(i)}) begin
                n_fail++; $display("FAIL ovf_hit%0d: got %h want %h", i, hit_q[i], {8'h20 + 8'(i), 12'h100 + 12'(i)});
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        hit_ready = 1'b1;
        put(hdr(16'h0003));
        put(dat(8'h31, 12'h031)); put(dat(8'h32, 12'h032));
        put(hdr(16'h0004));
        put(dat(8'h41, 12'h041));
        n_cmp++;
        if ({frame_done, frame_ok} !== 2'b10) begin
            n_fail++; $display("FAIL b2b_first_close: got %b want 10", {frame_done, frame_ok});
        end
        put(trl(16'd1));
        put(24'd0);
        n_cmp++;
        if ({frame_done, frame_ok} !== 2'b11) begin
            n_fail++; $display("FAIL b2b_second_close: got %b want 11", {frame_done, frame_ok});
        end
        repeat (3) put(24'd0);
        n_cmp++;
        if ({frame_cnt, err_flags, err_cnt, frame_num, fd_n[7:0], hit_q.size() == 3} !==
            {16'd2, 4'b0100, 8'd1, 16'h0004, 8'd2, 1'b1}) begin
            n_fail++; $display("FAIL b2b_stats: got %h want %h", {frame_cnt, err_flags, err_cnt, frame_num, fd_n[7:0], hit_q.size() == 3},
                                {16'd2, 4'b0100, 8'd1, 16'h0004, 8'd2, 1'b1});
        end
    endtask

    task automatic test_reset_mid();
        logic [75:0] all;
        do_reset();
        hit_ready = 1'b0;
        put(hdr(16'h0009));
        put(dat(8'h01, 12'h001)); put(dat(8'h02, 12'h002)); put(dat(8'h03, 12'h003));
        put(24'd0); put(24'd0);
        n_cmp++;
        if (hit_valid !== 1'b1) begin n_fail++; $display("FAIL mid_buffered: got %b want 1", hit_valid); end
        #2;
        sys_reset = 1'b0;
        #1;
        all = {hit_addr, hit_ts, hit_valid, frame_done, frame_ok, frame_num, frame_cnt, err_flags, err_cnt};
        n_cmp++;
        if (all !== 76'd0) begin n_fail++; $display("FAIL mid_async_reset: got %h want 0", all); end
        do_reset();
        hit_ready = 1'b1;
        put(hdr(16'h0050)); put(trl(16'd0));
        put(24'd0); put(24'd0);
        n_cmp++;
        if ({err_flags, err_cnt, frame_ok, frame_cnt, frame_num} !== {4'd0, 8'd0, 1'b1, 16'd1, 16'h0050}) begin
            n_fail++; $display("FAIL mid_after_reset: got %h want %h", {err_flags, err_cnt, frame_ok, frame_cnt, frame_num},
                                {4'd0, 8'd0, 1'b1, 16'd1, 16'h0050});
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_seq();
        test_count_orphan();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
